// File: rtl/seq_8b_piso_serializer.sv
// Parallel-in/serial-out transmitter: takes an NBITS word on a val/rdy port and
// drains it LSB first, one bit per val/rdy transfer, with zero-bubble reload.
//
// state | meaning
// IDLE  | no word held; ready to accept a new word
// SHIFT | presenting shreg[0]; advances on each accepted bit

module seq_8b_piso_serializer #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_msg,
  output logic             out_last
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBITS - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(NBITS - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CW-1:0]    count;

  // out_last is only ever set in SHIFT, so it alone marks the reload slot.
  assign in_rdy = reset && ((state == IDLE) || (out_last && out_rdy));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      count    <= '0;
      out_val  <= 1'b0;
      out_msg  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            state    <= SHIFT;
            shreg    <= in_msg;
            count    <= '0;
            out_val  <= 1'b1;
            out_msg  <= in_msg[0];
            out_last <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_rdy) begin
            if (count == LAST_IDX) begin
              count <= '0;
              if (in_val) begin
                shreg    <= in_msg;
                out_val  <= 1'b1;
                out_msg  <= in_msg[0];
                out_last <= 1'b0;
              end else begin
                state    <= IDLE;
                shreg    <= shreg >> 1;
                out_val  <= 1'b0;
                out_msg  <= 1'b0;
                out_last <= 1'b0;
              end
            end else begin
              shreg    <= shreg >> 1;
              count    <= count + 1'b1;
              out_msg  <= shreg[1];
              out_last <= (count == PRE_LAST_IDX);
            end
          end
        end
        default: begin
          state    <= IDLE;
          out_val  <= 1'b0;
          out_msg  <= 1'b0;
          out_last <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_8b_piso_serializer.sv
// Bench for seq_8b_piso_serializer: directed scenarios plus random traffic,
// checked against a queue-of-pending-bits reference model.

module tb_seq_8b_piso_serializer;

  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_val = 1'b0;
  logic             in_rdy;
  logic [NBITS-1:0] in_msg = '0;
  logic             out_val;
  logic             out_rdy = 1'b0;
  logic             out_msg;
  logic             out_last;

  seq_8b_piso_serializer #(.NBITS(NBITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  bit               q[$];
  bit               acc;
  logic [NBITS-1:0] cap;
  int               ov_cnt;
  int               cyc_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at negedge against the model, advance the model
  // for the transfers that the spec says occur at the next rising edge.
  task automatic cycle();
    bit e_val, e_msg, e_last, e_rdy;
    @(negedge clk);
    cyc_cnt++;
    if (!reset) begin
      chk("rst_in_rdy", in_rdy, 0);
      chk("rst_out_val", out_val, 0);
      chk("rst_out_msg", out_msg, 0);
      chk("rst_out_last", out_last, 0);
      q.delete();
    end else begin
      e_val  = (q.size() != 0);
      e_msg  = e_val ? q[0] : 1'b0;
      e_last = (q.size() == 1);
      e_rdy  = (q.size() == 0) || (q.size() == 1 && out_rdy);
      chk("out_val", out_val, e_val);
      chk("out_msg", out_msg, e_msg);
      chk("out_last", out_last, e_last);
      chk("in_rdy", in_rdy, e_rdy);
      if (out_val && out_rdy) cap = {out_msg, cap[NBITS-1:1]};
      if (out_val) ov_cnt++;
      if (e_val && out_rdy) void'(q.pop_front());
      if (in_val && e_rdy) begin
        for (int i = 0; i < NBITS; i++) q.push_back(in_msg[i]);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_accept();
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      cycle();
      n++;
    end
    chk("accept_timeout", {31'd0, acc}, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    // Reset held, then idle
    run(2);
    reset = 1'b1;
    run(3);

    // Single word, free-running sink
    out_rdy = 1'b1;
    in_msg  = 8'hA5;
    in_val  = 1'b1;
    wait_accept();
    in_val = 1'b0;
    in_msg = '0;
    run(NBITS);
    chk("a5_word", cap, 8'hA5);
    run(1);

    // Backpressure on the first bit
    out_rdy = 1'b0;
    in_msg  = 8'h81;
    in_val  = 1'b1;
    wait_accept();
    in_val = 1'b0;
    run(3);
    out_rdy = 1'b1;
    run(NBITS);
    chk("81_word", cap, 8'h81);
    run(1);

    // Back-to-back FF then 00
    in_msg = 8'hFF;
    in_val = 1'b1;
    wait_accept();
    ov_cnt  = 0;
    cyc_cnt = 0;
    in_msg  = 8'h00;
    wait_accept();
    in_val = 1'b0;
    drain();
    chk("b2b_val_cycles", ov_cnt, 16);
    chk("b2b_elapsed", cyc_cnt, 16);
    chk("b2b_second", cap, 8'h00);
    run(1);

    // Input ignored mid-word, accepted on last bit
    in_msg = 8'h0F;
    in_val = 1'b1;
    wait_accept();
    in_val = 1'b0;
    run(1);
    in_val = 1'b1;
    in_msg = 8'hF0;
    wait_accept();
    chk("0f_word", cap, 8'h0F);
    in_val = 1'b0;
    in_msg = 8'h5A;
    drain();
    chk("f0_word", cap, 8'hF0);
    run(1);

    // Reset mid-word
    in_msg = 8'hCC;
    in_val = 1'b1;
    wait_accept();
    in_val = 1'b0;
    run(3);
    reset = 1'b0;
    #1;
    chk("async_out_val", out_val, 0);
    chk("async_in_rdy", in_rdy, 0);
    q.delete();
    run(2);
    reset = 1'b1;
    run(NBITS + 2);

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 1500; i++) begin
      in_val  = ($urandom_range(0, 2) != 0);
      in_msg  = NBITS'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset  = 1'b1;
    in_val = 1'b0;
    out_rdy = 1'b1;
    drain();
    run(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seq_8b_piso_serializer.md
Name: seq_8b_piso_serializer

Overview:
- Parallel-in/serial-out transmitter. It accepts a captured NBITS-wide word on a val/rdy input interface and emits it one bit per transfer, LSB first, on a val/rdy output interface.
- It is the unload-side counterpart of the enabled 8-bit register stage: that stage writes a byte, and this block drains it bit-serially to a downstream deserializer or link.
- Sits between a byte-wide register/datapath and a 1-bit channel.

Parameters:
NBITS, 8, word width in bits; legal range 2..32; bit counter width is clog2(NBITS)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = normal operation
in_val  input  1  upstream word valid
in_rdy  output  1  block can accept a word this cycle
in_msg  input  NBITS  parallel word to serialize
out_val  output  1  serial bit valid
out_rdy  input  1  downstream accepts the bit this cycle
out_msg  output  1  current serial bit (LSB first)
out_last  output  1  current bit is bit NBITS-1 of the word

Behaviour:
- Reset (reset==0, asynchronous, immediate):
  - state=IDLE, shift register=0, count=0.
  - in_rdy=0, out_val=0, out_msg=0, out_last=0 while reset is asserted.
  - Reset asserted mid-word discards the word; no partial bits are emitted after release.
- States: IDLE, SHIFT.
- IDLE:
  - in_rdy=1, out_val=0, out_msg=0, out_last=0.
  - in_val&&in_rdy at the edge: shreg<=in_msg, count<=0, go to SHIFT.
  - in_val==0: stay in IDLE.
- SHIFT:
  - out_val=1, out_msg=shreg[0], out_last=(count==NBITS-1).
  - out_val&&out_rdy at the edge: shreg<=shreg>>1 (zero fill), count<=count+1.
  - If the transfer was the last bit, count<=0 and the next state follows the back-to-back rule below.
  - out_rdy==0: hold shreg, count, out_msg and out_last unchanged (stall). Outputs must stay stable while out_val&&!out_rdy.
- Back-to-back (zero bubble):
  - in_rdy = (state==IDLE) || (state==SHIFT && out_last && out_rdy). This is a combinational path from out_rdy to in_rdy.
  - If the last bit transfers and in_val==1 in the same cycle: load the new word, count<=0, stay in SHIFT.
  - If the last bit transfers and in_val==0: go to IDLE.
- In SHIFT with out_last==0: in_rdy=0 and in_val/in_msg are ignored.
- in_msg is sampled only on the accepting edge; later changes have no effect.
- Latency: first bit valid one cycle after the input transfer. With out_rdy held high, one word occupies exactly NBITS cycles of out_val.
- Throughput: one word per NBITS cycles with no idle cycle between words.
- No combinational path from in_val or in_msg to any output.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles -> in_rdy=0 and out_val=0. Release reset with in_val=0 for 3 cycles -> in_rdy=1, out_val=0, out_msg=0.
- Single word, free-running sink: in_msg=8'hA5 accepted, out_rdy=1 -> out_msg over 8 cycles = 1,0,1,0,0,1,0,1. out_last=1 only on the 8th bit. Next cycle out_val=0, in_rdy=1.
- Backpressure: in_msg=8'h81, out_rdy=0 for 3 cycles after the first bit appears -> out_msg held at 1, out_last=0 throughout the stall. Then out_rdy=1 -> remaining bits 0,0,0,0,0,0,1.
- Back-to-back: 8'hFF followed immediately by 8'h00, out_rdy=1 -> 16 consecutive out_val=1 cycles (eight 1s then eight 0s). in_rdy=1 only during the IDLE accept and on the last-bit cycle of the first word.
- Input ignored mid-word: after accepting 8'h0F, drive in_val=1, in_msg=8'hF0 during bits 2-6 -> serial output is still 1,1,1,1,0,0,0,0. 8'hF0 is accepted on the last-bit cycle and serialized next.
- Reset mid-word: accept 8'hCC, assert reset after 3 bits -> out_val drops to 0 immediately. After release, in_rdy=1, out_val=0, and no residual bits appear.
